fix_c_div: RTL and testbench
============================

# fix_c_div

Fixed-point complex divider: computes out = opa / opb = opa·conj(opb) / |opb|² on signed two's-complement operands, inverting the fixed-point complex multiply path. It sits in the fix-point arithmetic library beside the complex multiplier and is used where a complex gain must be removed, such as equalization and normalization. The block is sequential, with one transaction in flight. A shared restoring divider produces one quotient bit per cycle for the real and imaginary parts in parallel. Valid/ready handshakes are on both sides.

## Interface
- IN_WIDTH, 16, width of each signed input component
- OUT_WIDTH, 16, width of each signed output component
- FRAC_BITS, 12, fractional bits of the quotient (quotient value 1.0 = 2^FRAC_BITS)
- clk  input  1  clock; all state on rising edge
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- opa_R, opa_I  input  IN_WIDTH each  dividend, signed
- opb_R, opb_I  input  IN_WIDTH each  divisor, signed
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_R, out_I  output  OUT_WIDTH each  quotient, signed
- div_zero  output  1  result came from a zero divisor; qualified by out_valid

## Operation
- States are IDLE, CALC, DIV, FIN and HOLD.
- IDLE:
  - in_ready=1.
  - An in_valid&&in_ready edge registers the operands and moves to CALC.
- CALC (1 cycle) registers three values, all full precision with no intermediate truncation:
  - num_R = aR·bR + aI·bI (signed, 2·IN_WIDTH+1 bits)
  - num_I = aI·bR − aR·bI (signed, 2·IN_WIDTH+1 bits)
  - den = bR² + bI² (unsigned, 2·IN_WIDTH bits)
  - It also stores the num signs and the magnitudes |num|·2^FRAC_BITS, then moves to DIV.
- DIV (exactly OUT_WIDTH+1 cycles):
  - A bit counter runs the restoring division |num|·2^FRAC_BITS / den for both components at once.
  - A magnitude-overflow flag is set if any quotient bit at or above position OUT_WIDTH would be 1. This is a pre-check against den·2^OUT_WIDTH, or an equivalent.
  - The state moves to FIN when the counter wraps.
- FIN (1 cycle) computes q = sign·trunc(|num|·2^FRAC_BITS / den), which truncates toward zero.
  - q is saturated to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1].
  - The result is registered into out_R/out_I and the state moves to HOLD.
- HOLD:
  - out_valid=1, and outputs stay stable.
  - On an out_valid&&out_ready edge the state returns to IDLE.
- Divide by zero (den==0):
  - out_R=out_I=0 and div_zero=1.
  - Same state sequence and same latency as a normal divide.
  - div_zero=0 for every nonzero divisor.
- No overlap: in_ready=0 in every state except IDLE. in_valid is ignored there, and operands presented then are not captured.

## Timing
- Reset, async assert: state=IDLE, counter=0, in_ready=1, out_valid=0, out_R=0, out_I=0, div_zero=0, all datapath registers 0.
- Reset may assert in any state. The in-flight transaction is discarded and produces no out_valid.
- Latency is fixed. With acceptance on edge 0, out_valid rises after edge OUT_WIDTH+3. The sequence is CALC 1 cycle, DIV OUT_WIDTH+1 cycles, FIN 1 cycle.
- Latency is independent of operand values, including den==0 and saturation.
- If out_ready=1 when out_valid rises, HOLD lasts one cycle and in_ready returns on the next cycle. There is no same-cycle bypass from output to input.
- Throughput is at most one result per OUT_WIDTH+4 cycles.
- While out_ready=0, out_valid, out_R, out_I and div_zero hold indefinitely.

## Test plan
All cases use defaults IN=16, OUT=16, FRAC=12.
- Basic:
  - a=(100,200), b=(100,0) -> (4096, 8192), div_zero=0.
  - a=(0,100), b=(0,100) -> (4096, 0).
  - a=(3,0), b=(0,1) -> (0, −12288).
  - out_valid exactly 19 cycles after acceptance.
- Truncation toward zero:
  - a=(1,0), b=(3,0) -> (1365, 0).
  - a=(−1,0), b=(3,0) -> (−1365, 0).
- Saturation:
  - a=(32767,0), b=(1,0) -> (32767, 0).
  - a=(−32768,−32768), b=(1,0) -> (−32768, −32768).
- Divide by zero: a=(500,−7), b=(0,0) -> (0,0) with div_zero=1 at the normal latency. A following valid divide clears div_zero.
- Handshake:
  - Hold out_ready=0 for 10 cycles after out_valid: outputs stable, in_ready=0, and in_valid pulses are ignored.
  - Release out_ready: in_ready=1 on the next cycle.
  - Back-to-back random operands must match a golden model bit-exactly.
- Reset mid-DIV: assert rst_n=0 at cycle 8 after acceptance. All outputs go to reset values immediately and no out_valid appears. A new transaction after release completes correctly.

Source files
------------

// File: rtl/fix_c_div.sv
// Fixed-point complex divider: out = opa*conj(opb)/|opb|^2, one quotient bit per
// cycle for both components, valid/ready handshake on input and output.
module fix_c_div #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 16,
    parameter int FRAC_BITS = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  opa_R,
    input  logic [IN_WIDTH-1:0]  opa_I,
    input  logic [IN_WIDTH-1:0]  opb_R,
    input  logic [IN_WIDTH-1:0]  opb_I,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_R,
    output logic [OUT_WIDTH-1:0] out_I,
    output logic                 div_zero
);

    localparam int NUM_W = 2*IN_WIDTH + 1;
    localparam int DEN_W = 2*IN_WIDTH;
    localparam int R_W   = NUM_W + FRAC_BITS + OUT_WIDTH;
    localparam int CNT_W = $clog2(OUT_WIDTH + 1);

    localparam logic [OUT_WIDTH-1:0] MAX_POS = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] MIN_NEG = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, CALC, DIV, FIN, HOLD} state_t;

    state_t state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic signed [IN_WIDTH-1:0] a_r, a_i, b_r, b_i;
    logic [DEN_W-1:0] den;
    logic [R_W-1:0]   rem_r, rem_i, dvs;
    logic [OUT_WIDTH-1:0] q_r, q_i;
    logic neg_r, neg_i, ovf_r, ovf_i;

    logic signed [NUM_W-1:0] ar_x, ai_x, br_x, bi_x, num_r_c, num_i_c;
    logic signed [DEN_W-1:0] br_d, bi_d;
    logic [DEN_W-1:0] den_c;
    logic [NUM_W-1:0] mag_r_c, mag_i_c;
    logic ge_r, ge_i, cnt_last;

    // Full-precision products: operands are sign-extended before multiplying so
    // nothing is truncated before the division.
    always_comb begin
        ar_x    = NUM_W'(a_r);
        ai_x    = NUM_W'(a_i);
        br_x    = NUM_W'(b_r);
        bi_x    = NUM_W'(b_i);
        br_d    = DEN_W'(b_r);
        bi_d    = DEN_W'(b_i);
        num_r_c = ar_x*br_x + ai_x*bi_x;
        num_i_c = ai_x*br_x - ar_x*bi_x;
        den_c   = br_d*br_d + bi_d*bi_d;
        mag_r_c = num_r_c[NUM_W-1] ? -num_r_c : num_r_c;
        mag_i_c = num_i_c[NUM_W-1] ? -num_i_c : num_i_c;
    end

    assign ge_r     = (rem_r >= dvs);
    assign ge_i     = (rem_i >= dvs);
    assign cnt_last = (cnt == CNT_W'(OUT_WIDTH));

    function automatic logic [OUT_WIDTH-1:0] sat(input logic neg, input logic ovf,
                                                 input logic [OUT_WIDTH-1:0] mag);
        if (!neg) return (ovf || mag > MAX_POS) ? MAX_POS : mag;
        else      return (ovf || mag > MIN_NEG) ? MIN_NEG : -mag;
    endfunction

    // NOTE: every variable in this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = CALC;
            end
            CALC: state_nxt = DIV;
            DIV:  if (cnt_last) state_nxt = FIN;
            FIN:  state_nxt = HOLD;
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            a_r <= '0; a_i <= '0; b_r <= '0; b_i <= '0;
            den <= '0; dvs <= '0; rem_r <= '0; rem_i <= '0;
            q_r <= '0; q_i <= '0;
            neg_r <= 1'b0; neg_i <= 1'b0; ovf_r <= 1'b0; ovf_i <= 1'b0;
            out_R <= '0; out_I <= '0; div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_r <= opa_R; a_i <= opa_I;
                    b_r <= opb_R; b_i <= opb_I;
                end
                CALC: begin
                    neg_r <= num_r_c[NUM_W-1];
                    neg_i <= num_i_c[NUM_W-1];
                    rem_r <= R_W'(mag_r_c) << FRAC_BITS;
                    rem_i <= R_W'(mag_i_c) << FRAC_BITS;
                    den   <= den_c;
                    dvs   <= R_W'(den_c) << OUT_WIDTH;
                    q_r   <= '0; q_i <= '0;
                    ovf_r <= 1'b0; ovf_i <= 1'b0;
                    cnt   <= '0;
                end
                DIV: begin
                    if (ge_r) rem_r <= rem_r - dvs;
                    if (ge_i) rem_i <= rem_i - dvs;
                    // First step tests the quotient bit at OUT_WIDTH: a 1 there
                    // means the magnitude cannot fit and the result saturates.
                    if (cnt == '0) begin
                        ovf_r <= ge_r;
                        ovf_i <= ge_i;
                    end else begin
                        q_r <= {q_r[OUT_WIDTH-2:0], ge_r};
                        q_i <= {q_i[OUT_WIDTH-2:0], ge_i};
                    end
                    dvs <= dvs >> 1;
                    cnt <= cnt_last ? '0 : cnt + 1'b1;
                end
                FIN: begin
                    div_zero <= (den == '0);
                    out_R    <= (den == '0) ? '0 : sat(neg_r, ovf_r, q_r);
                    out_I    <= (den == '0) ? '0 : sat(neg_i, ovf_i, q_i);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fix_c_div.sv
// Directed-vector and model-based bench for fix_c_div (IN=16, OUT=16, FRAC=12):
// latency, truncation, saturation, divide-by-zero, back-pressure and mid-DIV reset.
module tb_fix_c_div;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, div_zero;
    logic [15:0] opa_R, opa_I, opb_R, opb_I, out_R, out_I;

    int n_checks = 0;
    int n_fail   = 0;

    fix_c_div #(.IN_WIDTH(16), .OUT_WIDTH(16), .FRAC_BITS(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .opa_R(opa_R), .opa_I(opa_I), .opb_R(opb_R), .opb_I(opb_I),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_R(out_R), .out_I(out_I), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ar, ai, br, bi;
        int er, ei;
        int ez;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint quot(input longint num, input longint den);
        longint mag, q;
        if (den == 0) return 0;
        mag = (num < 0) ? -num : num;
        q   = (mag * 4096) / den;
        if (num < 0) q = -q;
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        return q;
    endfunction

    task automatic send(input int ar, input int ai, input int br, input int bi);
        int t = 0;
        while (!in_ready && t < 100) begin
            @(posedge clk); #1; t++;
        end
        check("in_ready_wait", longint'(in_ready), 1);
        in_valid = 1'b1;
        opa_R = 16'(ar); opa_I = 16'(ai); opb_R = 16'(br); opb_I = 16'(bi);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    vec_t vecs[9];
    int   lat;

    initial begin
        vecs[0] = '{100, 200, 100, 0, 4096, 8192, 0};
        vecs[1] = '{0, 100, 0, 100, 4096, 0, 0};
        vecs[2] = '{3, 0, 0, 1, 0, -12288, 0};
        vecs[3] = '{1, 0, 3, 0, 1365, 0, 0};
        vecs[4] = '{-1, 0, 3, 0, -1365, 0, 0};
        vecs[5] = '{32767, 0, 1, 0, 32767, 0, 0};
        vecs[6] = '{-32768, -32768, 1, 0, -32768, -32768, 0};
        vecs[7] = '{500, -7, 0, 0, 0, 0, 1};
        vecs[8] = '{1, 0, 3, 0, 1365, 0, 0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        opa_R = '0; opa_I = '0; opb_R = '0; opb_I = '0;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_R", out_R, 0);
        check("rst_out_I", out_I, 0);
        check("rst_div_zero", div_zero, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            send(vecs[i].ar, vecs[i].ai, vecs[i].br, vecs[i].bi);
            wait_out(lat);
            check($sformatf("v%0d_latency", i), lat, 19);
            check($sformatf("v%0d_out_R", i), $signed(out_R), vecs[i].er);
            check($sformatf("v%0d_out_I", i), $signed(out_I), vecs[i].ei);
            check($sformatf("v%0d_div_zero", i), div_zero, vecs[i].ez);
            check($sformatf("v%0d_in_ready_busy", i), in_ready, 0);
            @(posedge clk); #1;
            check($sformatf("v%0d_in_ready_after", i), in_ready, 1);
            check($sformatf("v%0d_valid_drop", i), out_valid, 0);
        end

        // Back-pressure: result must hold and new operands must be ignored.
        out_ready = 1'b0;
        send(100, 200, 100, 0);
        wait_out(lat);
        check("bp_latency", lat, 19);
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            opa_R = 16'd7; opa_I = 16'd9; opb_R = 16'd1; opb_I = 16'd0;
            @(posedge clk); #1;
            check("bp_out_valid", out_valid, 1);
            check("bp_out_R", $signed(out_R), 4096);
            check("bp_out_I", $signed(out_I), 8192);
            check("bp_div_zero", div_zero, 0);
            check("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_valid", out_valid, 0);

        // Back-to-back random operands against the arithmetic model.
        for (int k = 0; k < 20; k++) begin
            int ar, ai, br, bi;
            longint nr, ni, dn;
            ar = $signed(16'($urandom));
            ai = $signed(16'($urandom));
            br = (k % 4 == 0) ? int'($urandom_range(0, 7)) - 3 : $signed(16'($urandom));
            bi = (k % 4 == 0) ? int'($urandom_range(0, 7)) - 3 : $signed(16'($urandom));
            nr = longint'(ar)*br + longint'(ai)*bi;
            ni = longint'(ai)*br - longint'(ar)*bi;
            dn = longint'(br)*br + longint'(bi)*bi;
            send(ar, ai, br, bi);
            wait_out(lat);
            check($sformatf("rnd%0d_latency", k), lat, 19);
            check($sformatf("rnd%0d_out_R", k), $signed(out_R), quot(nr, dn));
            check($sformatf("rnd%0d_out_I", k), $signed(out_I), quot(ni, dn));
            check($sformatf("rnd%0d_div_zero", k), div_zero, (dn == 0) ? 1 : 0);
        end
        @(posedge clk); #1;

        // Reset during DIV discards the transaction.
        send(-1, 0, 3, 0);
        repeat (7) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_R", out_R, 0);
        check("mid_rst_out_I", out_I, 0);
        check("mid_rst_div_zero", div_zero, 0);
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        begin
            int seen = 0;
            for (int c = 0; c < 25; c++) begin
                @(posedge clk); #1;
                if (out_valid) seen = 1;
            end
            check("mid_rst_no_valid", seen, 0);
        end
        send(0, 100, 0, 100);
        wait_out(lat);
        check("post_rst_latency", lat, 19);
        check("post_rst_out_R", $signed(out_R), 4096);
        check("post_rst_out_I", $signed(out_I), 0);
        check("post_rst_div_zero", div_zero, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
